// File: rtl/add_seq_pkg.sv
// Shared definitions for the byte-serial add/subtract sequencer.
package add_seq_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/adder_8bit_cin.sv
// Combinational byte-wide ripple adder with carry-in, chained from full adders.
module adder_8bit_cin
    import add_seq_pkg::*;
(
    input  logic [BYTE_W-1:0] a,
    input  logic [BYTE_W-1:0] b,
    input  logic              cin,
    output logic [BYTE_W-1:0] sum,
    output logic              cout
);

    logic [BYTE_W:0] carry;

    assign carry[0] = cin;
    assign cout     = carry[BYTE_W];

    genvar g;
    generate
        for (g = 0; g < BYTE_W; g++) begin : g_bit
            full_adder u_fa (
                .a    (a[g]),
                .b    (b[g]),
                .cin  (carry[g]),
                .sum  (sum[g]),
                .cout (carry[g+1])
            );
        end
    endgenerate

endmodule

// File: rtl/full_adder.sv
// One-bit full adder, the building block of the byte ripple adder.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    // Classic sum/carry equations.
    always_comb begin
        sum  = a ^ b ^ cin;
        cout = (a & b) | (cin & (a ^ b));
    end

endmodule

// File: rtl/multibyte_add_sequencer.sv
// Wide adder/subtractor that reuses a single byte adder over NUM_BYTES cycles,
// least significant byte first, carrying between bytes through a register.
module multibyte_add_sequencer
    import add_seq_pkg::*;
#(
    parameter int NUM_BYTES = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start_valid,
    output logic                        start_ready,
    input  logic [BYTE_W*NUM_BYTES-1:0] in1,
    input  logic [BYTE_W*NUM_BYTES-1:0] in2,
    input  logic                        sub,
    output logic                        result_valid,
    input  logic                        result_ready,
    output logic [BYTE_W*NUM_BYTES-1:0] out,
    output logic                        carry_out,
    output logic                        busy
);

    localparam int W     = BYTE_W * NUM_BYTES;
    localparam int IDX_W = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BYTES - 1);

    state_e            state_q, state_d;
    logic [W-1:0]      a_q, a_d;
    logic [W-1:0]      b_q, b_d;
    logic [W-1:0]      out_q, out_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              carry_q, carry_d;
    logic              carry_out_q, carry_out_d;

    logic [BYTE_W-1:0] a_byte, b_byte, byte_sum;
    logic              byte_cout;

    assign out       = out_q;
    assign carry_out = carry_out_q;

    // Pick the operand bytes addressed by the current byte index.
    always_comb begin
        a_byte = '0;
        b_byte = '0;
        for (int i = 0; i < NUM_BYTES; i++) begin
            if (idx_q == IDX_W'(i)) begin
                a_byte = a_q[i*BYTE_W +: BYTE_W];
                b_byte = b_q[i*BYTE_W +: BYTE_W];
            end
        end
    end

    adder_8bit_cin u_adder (
        .a    (a_byte),
        .b    (b_byte),
        .cin  (carry_q),
        .sum  (byte_sum),
        .cout (byte_cout)
    );

    // Next-state, datapath updates and handshake outputs; B is stored pre-inverted for subtraction.
    always_comb begin
        state_d      = state_q;
        a_d          = a_q;
        b_d          = b_q;
        out_d        = out_q;
        idx_d        = idx_q;
        carry_d      = carry_q;
        carry_out_d  = carry_out_q;
        start_ready  = 1'b0;
        result_valid = 1'b0;
        busy         = 1'b0;
        case (state_q)
            ST_IDLE: begin
                start_ready = 1'b1;
                if (start_valid) begin
                    a_d     = in1;
                    b_d     = sub ? ~in2 : in2;
                    carry_d = sub;
                    idx_d   = '0;
                    out_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                busy = 1'b1;
                for (int i = 0; i < NUM_BYTES; i++) begin
                    if (idx_q == IDX_W'(i)) begin
                        out_d[i*BYTE_W +: BYTE_W] = byte_sum;
                    end
                end
                carry_d = byte_cout;
                if (idx_q == LAST_IDX) begin
                    carry_out_d = byte_cout;
                    state_d     = ST_DONE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            ST_DONE: begin
                busy         = 1'b1;
                result_valid = 1'b1;
                if (result_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset taking priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            out_q       <= '0;
            idx_q       <= '0;
            carry_q     <= 1'b0;
            carry_out_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            out_q       <= out_d;
            idx_q       <= idx_d;
            carry_q     <= carry_d;
            carry_out_q <= carry_out_d;
        end
    end

endmodule

// File: tb/tb_multibyte_add_sequencer.sv
// Self-checking bench: a 4-byte and a 1-byte sequencer checked every cycle
// against a transaction-level model, plus directed literal cases.
module tb_multibyte_add_sequencer;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    // 4-byte instance signals
    logic        start_valid, start_ready, sub, result_valid, result_ready, carry_out, busy;
    logic [31:0] in1, in2, out;

    // 1-byte instance signals
    logic        start_valid_1, start_ready_1, sub_1, result_valid_1, result_ready_1, carry_out_1, busy_1;
    logic [7:0]  in1_1, in2_1, out_1;

    int n_cmp  = 0;
    int n_bad  = 0;
    bit chk_en = 1'b0;
    int cyc    = 0;

    multibyte_add_sequencer #(.NUM_BYTES(4)) dut4 (
        .clk(clk), .rst(rst),
        .start_valid(start_valid), .start_ready(start_ready),
        .in1(in1), .in2(in2), .sub(sub),
        .result_valid(result_valid), .result_ready(result_ready),
        .out(out), .carry_out(carry_out), .busy(busy)
    );

    multibyte_add_sequencer #(.NUM_BYTES(1)) dut1 (
        .clk(clk), .rst(rst),
        .start_valid(start_valid_1), .start_ready(start_ready_1),
        .in1(in1_1), .in2(in2_1), .sub(sub_1),
        .result_valid(result_valid_1), .result_ready(result_ready_1),
        .out(out_1), .carry_out(carry_out_1), .busy(busy_1)
    );

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: an accepted op yields A+B or A-B after NUM_BYTES edges,
    // held until the consumer takes it.
    logic        m4_busy, m4_valid, m4_co, m4_rco;
    int          m4_cnt;
    logic [31:0] m4_out, m4_res;
    logic        m1_busy, m1_valid, m1_co, m1_rco;
    int          m1_cnt;
    logic [7:0]  m1_out, m1_res;
    int          acc1_q[$];

    always @(negedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (rst) begin
            m4_busy <= 1'b0; m4_valid <= 1'b0; m4_cnt <= 0; m4_out <= '0; m4_co <= 1'b0;
        end else if (!m4_busy) begin
            if (start_valid) begin
                m4_busy <= 1'b1;
                m4_cnt  <= 4;
                if (sub) begin
                    m4_res <= in1 - in2;
                    m4_rco <= (in1 >= in2);
                end else begin
                    {m4_rco, m4_res} <= {1'b0, in1} + {1'b0, in2};
                end
            end
        end else if (!m4_valid) begin
            if (m4_cnt == 1) begin
                m4_valid <= 1'b1; m4_out <= m4_res; m4_co <= m4_rco;
            end
            m4_cnt <= m4_cnt - 1;
        end else if (result_ready) begin
            m4_valid <= 1'b0; m4_busy <= 1'b0;
        end
    end

    always @(posedge clk) begin
        if (rst) begin
            m1_busy <= 1'b0; m1_valid <= 1'b0; m1_cnt <= 0; m1_out <= '0; m1_co <= 1'b0;
        end else if (!m1_busy) begin
            if (start_valid_1) begin
                acc1_q.push_back(cyc);
                m1_busy <= 1'b1;
                m1_cnt  <= 1;
                if (sub_1) begin
                    m1_res <= in1_1 - in2_1;
                    m1_rco <= (in1_1 >= in2_1);
                end else begin
                    {m1_rco, m1_res} <= {1'b0, in1_1} + {1'b0, in2_1};
                end
            end
        end else if (!m1_valid) begin
            if (m1_cnt == 1) begin
                m1_valid <= 1'b1; m1_out <= m1_res; m1_co <= m1_rco;
            end
            m1_cnt <= m1_cnt - 1;
        end else if (result_ready_1) begin
            m1_valid <= 1'b0; m1_busy <= 1'b0;
        end
    end

    // Every-cycle comparison of both instances against the model; result data is
    // meaningful whenever no operation is in progress or a result is presented.
    always @(negedge clk) begin
        if (chk_en) begin
            checkOutput("nb4_start_ready", 64'(start_ready), 64'(!m4_busy));
            checkOutput("nb4_busy", 64'(busy), 64'(m4_busy));
            checkOutput("nb4_result_valid", 64'(result_valid), 64'(m4_valid));
            if (!m4_busy || m4_valid) begin
                checkOutput("nb4_out", 64'(out), 64'(m4_out));
                checkOutput("nb4_carry_out", 64'(carry_out), 64'(m4_co));
            end
            checkOutput("nb1_start_ready", 64'(start_ready_1), 64'(!m1_busy));
            checkOutput("nb1_busy", 64'(busy_1), 64'(m1_busy));
            checkOutput("nb1_result_valid", 64'(result_valid_1), 64'(m1_valid));
            if (!m1_busy || m1_valid) begin
                checkOutput("nb1_out", 64'(out_1), 64'(m1_out));
                checkOutput("nb1_carry_out", 64'(carry_out_1), 64'(m1_co));
            end
        end
    end

    // Present one operation to the 4-byte instance; returns #1 after the accept edge.
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic s);
        int guard = 0;
        while (start_ready !== 1'b1 && guard < 50) begin
            @(posedge clk); #1; guard++;
        end
        if (guard >= 50) checkOutput("nb4_start_ready_timeout", 64'(start_ready), 64'd1);
        in1 = a; in2 = b; sub = s; start_valid = 1'b1;
        @(posedge clk); #1;
        start_valid = 1'b0;
        in1 = $urandom; in2 = $urandom; sub = 1'($urandom);
    endtask

    task automatic wait_result(output int lat);
        lat = 0;
        while (result_valid !== 1'b1 && lat < 50) begin
            @(posedge clk); #1; lat++;
        end
    endtask

    task automatic release_result();
        result_ready = 1'b1;
        @(posedge clk); #1;
        result_ready = 1'b0;
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                          input logic [31:0] exp_out, input logic exp_co, input string tag);
        int lat;
        result_ready = 1'b0;
        applyStimulus(a, b, s);
        wait_result(lat);
        checkOutput({tag, "_latency"}, 64'(lat), 64'd4);
        checkOutput({tag, "_out"}, 64'(out), 64'(exp_out));
        checkOutput({tag, "_carry_out"}, 64'(carry_out), 64'(exp_co));
        release_result();
    endtask

    function automatic logic [31:0] pick32();
        case ($urandom % 4)
            0:       return 32'hFFFF_FFFF;
            1:       return 32'(($urandom % 4));
            default: return 32'($urandom);
        endcase
    endfunction

    initial begin
        int lat;
        rst = 1'b1;
        start_valid = 1'b0; in1 = '0; in2 = '0; sub = 1'b0; result_ready = 1'b0;
        start_valid_1 = 1'b0; in1_1 = '0; in2_1 = '0; sub_1 = 1'b0; result_ready_1 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk_en = 1'b1;

        checkOutput("reset_out", 64'(out), 64'd0);
        checkOutput("reset_carry_out", 64'(carry_out), 64'd0);
        checkOutput("reset_result_valid", 64'(result_valid), 64'd0);
        checkOutput("reset_busy", 64'(busy), 64'd0);
        checkOutput("reset_start_ready", 64'(start_ready), 64'd1);

        run_op(32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0, "add_ff_1");
        run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, "add_full_ripple");
        run_op(32'h0000_0005, 32'h0000_0007, 1'b1, 32'hFFFF_FFFE, 1'b0, "sub_5_7");
        run_op(32'h0000_0007, 32'h0000_0005, 1'b1, 32'h0000_0002, 1'b1, "sub_7_5");

        // Consumer stalls in DONE while the requester keeps pushing new work.
        result_ready = 1'b0;
        applyStimulus(32'hA5A5_0001, 32'h0000_F00F, 1'b1);
        wait_result(lat);
        checkOutput("stall_latency", 64'(lat), 64'd4);
        repeat (10) begin
            start_valid = 1'b1; in1 = $urandom; in2 = $urandom; sub = 1'($urandom);
            @(posedge clk); #1;
            checkOutput("stall_start_ready", 64'(start_ready), 64'd0);
            checkOutput("stall_result_valid", 64'(result_valid), 64'd1);
            checkOutput("stall_out", 64'(out), 64'hA5A4_0FF2);
            checkOutput("stall_carry_out", 64'(carry_out), 64'd1);
        end
        start_valid = 1'b0;
        release_result();
        checkOutput("stall_released_idle", 64'(start_ready), 64'd1);

        // Reset in the middle of a run, while the third byte is being processed.
        result_ready = 1'b0;
        applyStimulus(32'hDEAD_BEEF, 32'h0102_0304, 1'b0);
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checkOutput("midrun_rst_start_ready", 64'(start_ready), 64'd1);
        checkOutput("midrun_rst_out", 64'(out), 64'd0);
        checkOutput("midrun_rst_result_valid", 64'(result_valid), 64'd0);
        checkOutput("midrun_rst_busy", 64'(busy), 64'd0);
        run_op(32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0, "after_rst");

        // Single-byte instance: latency of one, then back-to-back throughput.
        result_ready_1 = 1'b0;
        in1_1 = 8'h80; in2_1 = 8'h80; sub_1 = 1'b0; start_valid_1 = 1'b1;
        @(posedge clk); #1;
        start_valid_1 = 1'b0;
        lat = 0;
        while (result_valid_1 !== 1'b1 && lat < 50) begin @(posedge clk); #1; lat++; end
        checkOutput("nb1_latency", 64'(lat), 64'd1);
        checkOutput("nb1_80_80_out", 64'(out_1), 64'h00);
        checkOutput("nb1_80_80_carry", 64'(carry_out_1), 64'd1);
        result_ready_1 = 1'b1;
        @(posedge clk); #1;
        acc1_q.delete();
        start_valid_1 = 1'b1;
        repeat (13) begin
            in1_1 = 8'($urandom); in2_1 = 8'($urandom); sub_1 = 1'($urandom);
            @(posedge clk); #1;
        end
        start_valid_1 = 1'b0;
        checkOutput("nb1_accept_count_ge4", 64'(acc1_q.size() >= 4), 64'd1);
        for (int i = 1; i < acc1_q.size(); i++) begin
            checkOutput("nb1_period", 64'(acc1_q[i] - acc1_q[i-1]), 64'd3);
        end
        repeat (3) begin @(posedge clk); #1; end

        // Randomised traffic on both instances with occasional resets.
        repeat (800) begin
            start_valid  = ($urandom % 3) != 0;
            in1 = pick32(); in2 = pick32(); sub = 1'($urandom);
            result_ready = ($urandom % 2) == 0;
            start_valid_1  = ($urandom % 3) != 0;
            in1_1 = 8'($urandom); in2_1 = 8'($urandom); sub_1 = 1'($urandom);
            result_ready_1 = ($urandom % 2) == 0;
            rst = ($urandom % 150) == 0;
            @(posedge clk); #1;
        end
        rst = 1'b0; start_valid = 1'b0; start_valid_1 = 1'b0;
        result_ready = 1'b1; result_ready_1 = 1'b1;
        repeat (10) begin @(posedge clk); #1; end

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
